vx_split_join_ctrl: RTL
=======================

// Module: VX_split_join_ctrl
// PURPOSE
//  Per-warp divergence controller upstream of the IPDOM stack. Takes split/join requests from
//  the warp scheduler's ALU branch path, computes then/else masks, and drives push/pop/q0/q1.
//  Turns popped entries into thread-mask and PC updates. The stack is instantiated beside it.
// PARAMETERS
//  NUM_THREADS  4   threads per warp (mask width)
//  PC_BITS      32  PC width
//  DEPTH        4   IPDOM stack depth, power of two; ADDRW = LOG2UP(DEPTH)
//  STACK_LAT    0   stack read latency in cycles (0 = LUTRAM, 1 = output-registered)
// PORTS
//  clk            in   1            clock
//  reset          in   1            asynchronous, active-low reset
//  req_valid      in   1            split/join request
//  req_ready      out  1            request accepted when valid&ready
//  req_is_join    in   1            0 = split, 1 = join
//  req_tmask      in   NUM_THREADS  current warp thread mask
//  req_taken      in   NUM_THREADS  per-thread predicate (split only)
//  req_pc         in   PC_BITS      split: else-path PC; join: ignored
//  req_ptr        in   ADDRW        join: ptr returned by the matching split
//  rsp_valid      out  1            one-cycle pulse per accepted request
//  rsp_is_join    out  1            echoes request type
//  rsp_divergent  out  1            split: both paths non-empty
//  rsp_tmask      out  NUM_THREADS  new warp thread mask
//  rsp_jump       out  1            warp must redirect to rsp_pc
//  rsp_pc         out  PC_BITS      redirect target
//  rsp_ptr        out  ADDRW        split: stk_q_ptr sampled before the push
//  stk_push/pop   out  1            stack controls
//  stk_q0, stk_q1 out  NT+PC_BITS   push data {mask,pc}
//  stk_d          in   NT+PC_BITS   top entry; stk_d_set in 1: 1 = else entry, 0 = restore entry
//  stk_q_ptr      in   ADDRW        stack write pointer; stk_empty/stk_full in 1 each
// BEHAVIOUR
//  - Reset: state IDLE, settle count 0, rsp_* = 0, stk_push/pop = 0, req_ready = 0 while asserted.
//  - FSM IDLE/SETTLE. IDLE: req_ready = 1, except a divergent split with stk_full stalls (ready 0).
//    Any push/pop with STACK_LAT>0 -> SETTLE for STACK_LAT cycles (ready 0) -> IDLE.
//  - stk_push/stk_pop are combinational on acceptance. Never both in one cycle.
//  - Split: then = tmask&taken, else = tmask&~taken, div = |then && |else.
//    div: push q1 = {else, req_pc}, q0 = {tmask, '0}; rsp_tmask = then.
//    !div: no push; rsp_tmask = req_tmask. rsp_jump = 0 in both cases.
//    rsp_ptr = stk_q_ptr pre-push.
//  - Join: match = (req_ptr + 1 == stk_q_ptr), mod 2^ADDRW. No match or stk_empty: no pop,
//    rsp_tmask = req_tmask, rsp_jump = 0.
//    Match: pop. stk_d_set = 1 -> rsp_tmask = d.mask, rsp_pc = d.pc, rsp_jump = 1.
//    stk_d_set = 0 -> rsp_tmask = d.mask, rsp_jump = 0. Ptr is unchanged after the first pop,
//    so the second join on the same ptr matches again.
//  - rsp_* registered: 1 cycle after acceptance, no backpressure.
//  - Reset mid-SETTLE aborts to IDLE. The stack must be reset by the same event.
// CONFIGURATION
//  SPLIT_JOIN_PERF_EN defined: adds out perf_div_splits[31:0] (divergent pushes) and
//    perf_full_stalls[31:0] (cycles stalled on stk_full). Both wrap, reset to 0.
//  Undefined: ports and counters absent, behaviour otherwise identical.
// STRUCTURE
//  VX_gpu_pkg gets typedef ipdom_entry_t {logic [NT-1:0] tmask; logic [PC_BITS-1:0] pc;}
//  and the SJ_* FSM state enum. No sub-module; the stack stays in the parent.
// TESTING
//  1 NT=4, tmask=1111, taken=0011, pc=0x100 -> push q1={1100,0x100}, q0={1111,0}; rsp_tmask=0011,
//    div=1, ptr=0.
//  2 Then join ptr=0 (q_ptr=1) -> pop, d_set=1: rsp_tmask=1100, jump=1, pc=0x100.
//    Second join ptr=0 -> rsp_tmask=1111, jump=0; q_ptr returns to 0.
//  3 Split taken=1111 -> no push, div=0, ptr=0. Join ptr=0 with q_ptr=0 -> no pop,
//    rsp_tmask=req_tmask.
//  4 DEPTH=4: 4 nested divergent splits -> full. 5th divergent split: ready=0 until a join pops.
//    Ptr wrap 3+1==0 matches.
//  5 STACK_LAT=1: push then immediate join request -> ready=0 for 1 cycle, then join uses settled d.
//  6 Assert reset in SETTLE -> rsp_valid=0, ready=0. Release -> ready=1 next cycle, perf counters 0.

Source files
------------

// File: rtl/vx_split_join_ctrl_pkg.sv
// Shared types for the split/join divergence controller.
// ipdom_entry_t is the {mask, pc} stack entry at the default widths; the
// controller rebuilds the same layout locally at its own parameter widths.
package vx_split_join_ctrl_pkg;

    localparam int unsigned SJ_NUM_THREADS = 4;
    localparam int unsigned SJ_PC_BITS     = 32;

    typedef struct packed {
        logic [SJ_NUM_THREADS-1:0] tmask;
        logic [SJ_PC_BITS-1:0]     pc;
    } ipdom_entry_t;

    typedef enum logic [0:0] {
        SJ_IDLE   = 1'b0,
        SJ_SETTLE = 1'b1
    } sj_state_e;

    // Address width with a floor of one bit.
    function automatic int unsigned log2up(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_split_join_ctrl.sv
// Per-warp divergence controller in front of the IPDOM stack.
// It takes split/join requests and computes the then/else masks. It drives the
// stack push/pop with {mask,pc} entries and turns popped entries into mask/PC updates.
// Ports: clk, reset (async, active-low); req_* request handshake and payload;
//        rsp_* one-cycle registered response; stk_* stack control/status.
// Optional: define SPLIT_JOIN_PERF_EN to add the perf_div_splits and
//           perf_full_stalls counters.
module vx_split_join_ctrl
    import vx_split_join_ctrl_pkg::*;
#(
    parameter int unsigned NUM_THREADS = SJ_NUM_THREADS,
    parameter int unsigned PC_BITS     = SJ_PC_BITS,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned STACK_LAT   = 0,
    localparam int unsigned ADDRW      = log2up(DEPTH),
    localparam int unsigned EW         = NUM_THREADS + PC_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_is_join,
    input  logic [NUM_THREADS-1:0] req_tmask,
    input  logic [NUM_THREADS-1:0] req_taken,
    input  logic [PC_BITS-1:0]     req_pc,
    input  logic [ADDRW-1:0]       req_ptr,
    output logic                   rsp_valid,
    output logic                   rsp_is_join,
    output logic                   rsp_divergent,
    output logic [NUM_THREADS-1:0] rsp_tmask,
    output logic                   rsp_jump,
    output logic [PC_BITS-1:0]     rsp_pc,
    output logic [ADDRW-1:0]       rsp_ptr,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic [EW-1:0]          stk_q0,
    output logic [EW-1:0]          stk_q1,
    input  logic [EW-1:0]          stk_d,
    input  logic                   stk_d_set,
    input  logic [ADDRW-1:0]       stk_q_ptr,
    input  logic                   stk_empty,
    input  logic                   stk_full
`ifdef SPLIT_JOIN_PERF_EN
    ,
    output logic [31:0]            perf_div_splits,
    output logic [31:0]            perf_full_stalls
`endif
);

    localparam int unsigned CNTW = log2up(STACK_LAT + 1);

    typedef struct packed {
        logic [NUM_THREADS-1:0] tmask;
        logic [PC_BITS-1:0]     pc;
    } entry_t;

    sj_state_e              state, state_nxt;
    logic [CNTW-1:0]        cnt, cnt_nxt;
    logic                   rdy_en;
    entry_t                 d_ent;
    logic [NUM_THREADS-1:0] then_m, else_m;
    logic                   div_c, match_c, stall_c, accept_c;
    logic                   n_div, n_jump;
    logic [NUM_THREADS-1:0] n_tmask;
    logic [PC_BITS-1:0]     n_pc;

    assign d_ent  = entry_t'(stk_d);
    assign stk_q1 = {else_m, req_pc};
    assign stk_q0 = {req_tmask, {PC_BITS{1'b0}}};

    // Mask split, join pointer match (wraps mod 2^ADDRW) and full-stack stall.
    always_comb begin
        then_m  = req_tmask & req_taken;
        else_m  = req_tmask & ~req_taken;
        div_c   = (|then_m) && (|else_m);
        match_c = (ADDRW'(req_ptr + ADDRW'(1)) == stk_q_ptr);
        stall_c = !req_is_join && div_c && stk_full;
    end

    // State register; rdy_en holds ready low until the first edge after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= SJ_IDLE;
            cnt    <= '0;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rdy_en <= 1'b1;
        end
    end

    // Next state, handshake, stack controls and response payload.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        accept_c  = 1'b0;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        n_div     = 1'b0;
        n_jump    = 1'b0;
        n_tmask   = req_tmask;
        n_pc      = '0;
        case (state)
            SJ_IDLE: begin
                req_ready = rdy_en && !stall_c;
                accept_c  = req_valid && req_ready;
                if (accept_c) begin
                    if (!req_is_join) begin
                        n_div = div_c;
                        if (div_c) begin
                            stk_push = 1'b1;
                            n_tmask  = then_m;
                        end
                    end else if (match_c && !stk_empty) begin
                        stk_pop = 1'b1;
                        n_tmask = d_ent.tmask;
                        if (stk_d_set) begin
                            n_jump = 1'b1;
                            n_pc   = d_ent.pc;
                        end
                    end
                    // Give the stack's registered read time to reflect the update.
                    if ((STACK_LAT != 0) && (stk_push || stk_pop)) begin
                        state_nxt = SJ_SETTLE;
                        cnt_nxt   = '0;
                    end
                end
            end
            SJ_SETTLE: begin
                if (cnt == CNTW'(STACK_LAT - 1)) begin
                    state_nxt = SJ_IDLE;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            default: state_nxt = SJ_IDLE;
        endcase
    end

    // Registered response, one cycle after acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid     <= 1'b0;
            rsp_is_join   <= 1'b0;
            rsp_divergent <= 1'b0;
            rsp_tmask     <= '0;
            rsp_jump      <= 1'b0;
            rsp_pc        <= '0;
            rsp_ptr       <= '0;
        end else begin
            rsp_valid <= accept_c;
            if (accept_c) begin
                rsp_is_join   <= req_is_join;
                rsp_divergent <= n_div;
                rsp_tmask     <= n_tmask;
                rsp_jump      <= n_jump;
                rsp_pc        <= n_pc;
                rsp_ptr       <= stk_q_ptr;
            end
        end
    end

`ifdef SPLIT_JOIN_PERF_EN
    // Wrapping event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_div_splits  <= '0;
            perf_full_stalls <= '0;
        end else begin
            if (stk_push) begin
                perf_div_splits <= perf_div_splits + 32'd1;
            end
            if ((state == SJ_IDLE) && rdy_en && req_valid && stall_c) begin
                perf_full_stalls <= perf_full_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
